// File: rtl/n_acq_pkg.sv
// Shared types and widths for the acquisition reset/start sequencer.
// The FSM encoding and phase-width helper live here so the top and the phase counter agree.
package n_acq_pkg;

    localparam int CNT_W = 16;
    localparam int PW_W  = 8;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RST  = 3'd1,
        S_GAP  = 3'd2,
        S_ACQ  = 3'd3,
        S_WAIT = 3'd4,
        S_FIN  = 3'd5
    } acq_state_t;

    // Reset and acquire phases must last at least one cycle even when programmed as zero.
    function automatic logic [PW_W-1:0] eff_width(input logic [PW_W-1:0] w);
        return (w == '0) ? PW_W'(1) : w;
    endfunction

endpackage

// File: rtl/n_acq_phase_cnt.sv
// Loadable down-counter timing the RST/GAP/ACQ phases; zero marks the last cycle of a phase.
// Loading width-1 on phase entry makes a phase last exactly "width" cycles.
module n_acq_phase_cnt
    import n_acq_pkg::*;
(
    input  logic            clk_sys,
    input  logic            rst,
    input  logic            load,
    input  logic [PW_W-1:0] load_val,
    output logic            zero
);

    logic [PW_W-1:0] cnt_reg;

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - PW_W'(1);
        end
    end

    assign zero = (cnt_reg == '0);

endmodule

// File: rtl/n_acq_gen.sv
// Acquisition sequencer: repeats reset-pulse / gap / acquire-start pulses echo_cnt times,
// each repetition starting a fixed period after the previous reset pulse began.
module n_acq_gen
    import n_acq_pkg::*;
(
    input  logic             clk_sys,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] echo_cnt,
    input  logic [PW_W-1:0]  rst_width,
    input  logic [PW_W-1:0]  gap_width,
    input  logic [PW_W-1:0]  acq_width,
    input  logic [CNT_W-1:0] period,
    output logic             n_rst_n,
    output logic             n_acq_start,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] acq_idx
);

    acq_state_t       state_reg, state_next;
    logic [PW_W-1:0]  rw_reg, gw_reg, aw_reg;
    logic [CNT_W-1:0] echo_reg, pe_m1_reg;
    logic [CNT_W-1:0] per_cnt_reg, acq_idx_reg;
    logic             n_rst_n_reg, n_acq_start_reg, busy_reg, done_reg;

    logic             ph_load;
    logic [PW_W-1:0]  ph_val;
    logic             ph_zero;
    logic             acq_end;

    // Effective parameters derived from the live inputs, used only at the start cycle.
    logic [PW_W-1:0]  rw_in, aw_in;
    logic [CNT_W-1:0] phase_sum, pe_in;
    logic             start_acc, last_acq, period_hit;

    assign rw_in     = eff_width(rst_width);
    assign aw_in     = eff_width(acq_width);
    assign phase_sum = CNT_W'(rw_in) + CNT_W'(gap_width) + CNT_W'(aw_in);
    assign pe_in     = (period > phase_sum) ? period : phase_sum;

    assign start_acc  = (state_reg == S_IDLE) && start && !abort;
    assign last_acq   = ({1'b0, acq_idx_reg} + 17'd1) >= {1'b0, echo_reg};
    assign period_hit = (per_cnt_reg == pe_m1_reg);

    n_acq_phase_cnt u_phase_cnt (
        .clk_sys  (clk_sys),
        .rst      (rst),
        .load     (ph_load),
        .load_val (ph_val),
        .zero     (ph_zero)
    );

    always_comb begin
        state_next = state_reg;
        ph_load    = 1'b0;
        ph_val     = '0;
        acq_end    = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start_acc) begin
                    if (echo_cnt == '0) begin
                        state_next = S_FIN;
                    end else begin
                        state_next = S_RST;
                        ph_load    = 1'b1;
                        ph_val     = rw_in - PW_W'(1);
                    end
                end
            end
            S_RST: begin
                if (ph_zero) begin
                    ph_load = 1'b1;
                    if (gw_reg != '0) begin
                        state_next = S_GAP;
                        ph_val     = gw_reg - PW_W'(1);
                    end else begin
                        state_next = S_ACQ;
                        ph_val     = aw_reg - PW_W'(1);
                    end
                end
            end
            S_GAP: begin
                if (ph_zero) begin
                    state_next = S_ACQ;
                    ph_load    = 1'b1;
                    ph_val     = aw_reg - PW_W'(1);
                end
            end
            S_ACQ: begin
                if (ph_zero) begin
                    acq_end = 1'b1;
                    if (last_acq) begin
                        state_next = S_FIN;
                    end else if (period_hit) begin
                        state_next = S_RST;
                        ph_load    = 1'b1;
                        ph_val     = rw_reg - PW_W'(1);
                    end else begin
                        state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (period_hit) begin
                    state_next = S_RST;
                    ph_load    = 1'b1;
                    ph_val     = rw_reg - PW_W'(1);
                end
            end
            S_FIN: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        // Abort overrides everything, including the acquisition count update.
        if (abort && (state_reg != S_IDLE)) begin
            state_next = S_IDLE;
            ph_load    = 1'b0;
            acq_end    = 1'b0;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_reg       <= S_IDLE;
            rw_reg          <= '0;
            gw_reg          <= '0;
            aw_reg          <= '0;
            echo_reg        <= '0;
            pe_m1_reg       <= '0;
            per_cnt_reg     <= '0;
            acq_idx_reg     <= '0;
            n_rst_n_reg     <= 1'b0;
            n_acq_start_reg <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
        end else begin
            state_reg <= state_next;

            if (start_acc) begin
                rw_reg      <= rw_in;
                gw_reg      <= gap_width;
                aw_reg      <= aw_in;
                echo_reg    <= echo_cnt;
                pe_m1_reg   <= pe_in - CNT_W'(1);
                acq_idx_reg <= '0;
            end else if (acq_end && (acq_idx_reg != '1)) begin
                acq_idx_reg <= acq_idx_reg + CNT_W'(1);
            end

            // Period reference is the first cycle of every reset pulse.
            if ((state_next == S_RST) && (state_reg != S_RST)) begin
                per_cnt_reg <= '0;
            end else if (per_cnt_reg != '1) begin
                per_cnt_reg <= per_cnt_reg + CNT_W'(1);
            end

            // Outputs are registered from the next state so they line up with it.
            n_rst_n_reg     <= (state_next != S_RST);
            n_acq_start_reg <= (state_next == S_ACQ);
            busy_reg        <= (state_next == S_RST) || (state_next == S_GAP) ||
                               (state_next == S_ACQ) || (state_next == S_WAIT);
            done_reg        <= (state_next == S_FIN);
        end
    end

    assign n_rst_n     = n_rst_n_reg;
    assign n_acq_start = n_acq_start_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign acq_idx     = acq_idx_reg;

endmodule
